// File: rtl/mmio_timer_pkg.sv
// Shared register map and CTRL bit layout for the mmio_timer peripheral family.
// Constants only; no clocked logic and no flow control.
package mmio_timer_pkg;

  localparam logic [2:0] OFS_CTRL  = 3'd0;
  localparam logic [2:0] OFS_COUNT = 3'd1;
  localparam logic [2:0] OFS_CMP   = 3'd2;
  localparam logic [2:0] OFS_STAT  = 3'd3;
  localparam logic [2:0] OFS_PRE   = 3'd4;

  localparam int EN     = 0;
  localparam int RELOAD = 1;
  localparam int IE     = 2;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0400;

endpackage

// File: rtl/mmio_bus_slave.sv
// 32-byte MMIO window: address decode, per-word write enables, registered read mux.
// Writes apply in the strobe cycle, reads return one cycle later; never stalls the core.
module mmio_bus_slave
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic [31:0]      daddr,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic [7:0][31:0] reg_words,
  output logic [7:0]       wr_en,
  output logic [31:0]      rdata,
  output logic             rsel
);

  logic       hit;
  logic [2:0] ofs;
  logic       unused_lsb;

  assign hit        = (daddr[31:5] == BASE_ADDR[31:5]);
  assign ofs        = daddr[4:2];
  assign unused_lsb = ^daddr[1:0];

  always_comb begin
    wr_en = '0;
    if (dmem_write && hit) wr_en[ofs] = 1'b1;
  end

  // reg_words reflects the registers before this edge, so a same-cycle write is not seen
  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      rdata <= '0;
      rsel  <= 1'b0;
    end else begin
      rsel  <= dmem_read && hit;
      rdata <= (dmem_read && hit) ? reg_words[ofs] : 32'd0;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Free-running 32-bit timer with compare, sticky pend flag and level irq; reads take 1 cycle.
// No backpressure; optional PRESCALE register under MMIO_TIMER_PRESCALE_EN.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic [31:0] daddr,
  input  logic [31:0] wdata,
  input  logic        dmem_read,
  input  logic        dmem_write,
  output logic [31:0] rdata,
  output logic        rsel,
  output logic        irq
);

  logic [2:0]       ctrl_q;
  logic [31:0]      count_q;
  logic [31:0]      cmp_q;
  logic             pend_q;
  logic             tick;
  logic             match;
  logic [7:0]       wr_en;
  logic [7:0][31:0] reg_words;

  mmio_bus_slave #(.BASE_ADDR(BASE_ADDR)) u_bus (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .daddr      (daddr),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .reg_words  (reg_words),
    .wr_en      (wr_en),
    .rdata      (rdata),
    .rsel       (rsel)
  );

`ifdef MMIO_TIMER_PRESCALE_EN
  logic [15:0] pre_q;
  logic [15:0] pre_cnt_q;
  logic        unused_wr;

  assign unused_wr = ^wr_en[7:5];
  assign tick      = ctrl_q[EN] && (pre_cnt_q == pre_q);

  // Phase restarts whenever the timer is stopped or the divider is changed
  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      pre_q     <= '0;
      pre_cnt_q <= '0;
    end else begin
      if (wr_en[OFS_PRE]) pre_q <= wdata[15:0];
      if (!ctrl_q[EN] || wr_en[OFS_PRE] || tick) pre_cnt_q <= '0;
      else                                       pre_cnt_q <= pre_cnt_q + 16'd1;
    end
  end
`else
  logic unused_wr;

  assign unused_wr = ^wr_en[7:4];
  assign tick      = ctrl_q[EN];
`endif

  assign match = tick && (count_q == cmp_q);
  assign irq   = pend_q && ctrl_q[IE];

  always_comb begin
    reg_words            = '0;
    reg_words[OFS_CTRL]  = {29'd0, ctrl_q};
    reg_words[OFS_COUNT] = count_q;
    reg_words[OFS_CMP]   = cmp_q;
    reg_words[OFS_STAT]  = {31'd0, pend_q};
`ifdef MMIO_TIMER_PRESCALE_EN
    reg_words[OFS_PRE]   = {16'd0, pre_q};
`endif
  end

  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= RESET_COMPARE;
      pend_q  <= 1'b0;
    end else begin
      if (wr_en[OFS_CTRL]) ctrl_q <= wdata[2:0];
      if (wr_en[OFS_CMP])  cmp_q  <= wdata;
      // Software COUNT write beats both increment and reload
      if (wr_en[OFS_COUNT]) count_q <= wdata;
      else if (tick)        count_q <= (match && ctrl_q[RELOAD]) ? 32'd0 : count_q + 32'd1;
      if (match)                            pend_q <= 1'b1;
      else if (wr_en[OFS_STAT] && wdata[0]) pend_q <= 1'b0;
    end
  end

endmodule
